draw_write_manager: RTL and testbench

DRAW_WRITE_MANAGER -- requirements
Module: draw_write_manager

---
 rtl/draw_write_manager_pkg.sv | 29 ++
 rtl/draw_write_manager_if.sv | 29 ++
 rtl/draw_pixel_addr.sv | 51 +++++
 rtl/draw_write_manager.sv | 163 ++++++++++++++++
 tb/tb_draw_write_manager.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_write_manager_pkg.sv
// Shared frame-manager constants and types for the draw write path.
// Holds the framebuffer geometry, bus widths, the compose FSM state enum
// and a helper for X/Z-safe sampling of single-bit bus inputs.
package draw_write_manager_pkg;

  localparam int DRAW_WIDTH        = 640;
  localparam int DRAW_HEIGHT       = 480;
  localparam int DRAW_WIDTH_ADDRW  = 10;
  localparam int DRAW_HEIGHT_ADDRW = 9;
  localparam int FB_ADDRW          = DRAW_WIDTH_ADDRW + DRAW_HEIGHT_ADDRW;
  localparam int COLOR_DEPTH       = 8;
  localparam int SOURCE_SEL_ADDRW  = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SELECT,
    AWAIT,
    STREAM,
    NEXT,
    DONE
  } dwm_state_e;

  // The draw bus is shared and may float; anything but a clean 1 reads as 0.
  function automatic logic is_high(input logic b);
    return (b === 1'b1);
  endfunction

endpackage

// File: rtl/draw_write_manager_if.sv
// Shared draw-source bus.
//   write_source_sel / write_awaited : manager -> sources (who may stream)
//   write_active, write_color_data, write_transparent,
//   write_x_addr, write_y_addr       : selected source -> manager
// master = compose manager, slave = a draw source.
interface draw_write_manager_if;
  import draw_write_manager_pkg::*;

  logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
  logic                         write_awaited;
  logic                         write_active;
  logic [COLOR_DEPTH-1:0]       write_color_data;
  logic                         write_transparent;
  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr;
  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;

  modport master (
    output write_source_sel, write_awaited,
    input  write_active, write_color_data, write_transparent,
           write_x_addr, write_y_addr
  );

  modport slave (
    input  write_source_sel, write_awaited,
    output write_active, write_color_data, write_transparent,
           write_x_addr, write_y_addr
  );

endinterface

// File: rtl/draw_pixel_addr.sv
// Pixel coordinate to linear framebuffer address, with bounds check.
//   clk, resetN : clock, async active-low reset
//   sample_en   : capture x/y this cycle
//   x, y        : pixel coordinates from the draw bus
//   addr        : registered y*DRAW_W + x (0 when out of bounds)
//   in_bounds   : registered x<DRAW_W && y<DRAW_H && address fits fb_addr
module draw_pixel_addr
  import draw_write_manager_pkg::*;
#(
  parameter int DRAW_W = DRAW_WIDTH,
  parameter int DRAW_H = DRAW_HEIGHT
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         sample_en,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  x,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] y,
  output logic [FB_ADDRW-1:0]          addr,
  output logic                         in_bounds
);

  localparam logic [31:0] W32 = 32'(DRAW_W);
  localparam logic [31:0] H32 = 32'(DRAW_H);

  logic [31:0] x32;
  logic [31:0] y32;
  logic [31:0] lin;
  logic        ovf;
  logic        inb;

  // Product kept at 32 bits; any address that would not fit fb_addr is
  // treated as out of bounds rather than silently wrapped.
  always_comb begin
    x32 = 32'(x);
    y32 = 32'(y);
    lin = y32 * W32 + x32;
    ovf = |lin[31:FB_ADDRW];
    inb = (x32 < W32) && (y32 < H32) && !ovf;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addr      <= '0;
      in_bounds <= 1'b0;
    end else if (sample_en) begin
      addr      <= inb ? lin[FB_ADDRW-1:0] : '0;
      in_bounds <= inb;
    end
  end

endmodule

// File: rtl/draw_write_manager.sv
// Frame compose manager: optionally clears the framebuffer, then polls each
// draw source in turn over the shared draw bus and forwards its pixels to
// the framebuffer write port.
//   clk, resetN          : clock, async active-low reset
//   frame_start          : pulse, start one compose (ignored when busy)
//   clear_en, bg_color   : fill framebuffer with bg_color first
//   bus (master)         : shared draw-source bus
//   fb_we/fb_addr/fb_wdata : framebuffer write port (always accepting)
//   frame_done           : pulse, compose finished
//   source_timeout       : pulse, selected source never became active
//   frame_overrun        : pulse, frame_start arrived while busy
//
// state  | meaning
// IDLE   | waiting for frame_start
// CLEAR  | writing bg_color, one address per cycle
// SELECT | addressing source idx, arming timeout
// AWAIT  | waiting for write_active (first active cycle is a pixel)
// STREAM | one pixel per active cycle, ends on first inactive cycle
// NEXT   | write_awaited low for a cycle, advance idx
// DONE   | frame_done pulse
module draw_write_manager
  import draw_write_manager_pkg::*;
#(
  parameter int SOURCE_COUNT  = 4,
  parameter int AWAIT_TIMEOUT = 16,
  parameter int DRAW_W        = DRAW_WIDTH,
  parameter int DRAW_H        = DRAW_HEIGHT
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame_start,
  input  logic                   clear_en,
  input  logic [COLOR_DEPTH-1:0] bg_color,
  draw_write_manager_if.master   bus,
  output logic                   fb_we,
  output logic [FB_ADDRW-1:0]    fb_addr,
  output logic [COLOR_DEPTH-1:0] fb_wdata,
  output logic                   frame_done,
  output logic                   source_timeout,
  output logic                   frame_overrun
);

  localparam int TMO_W = $clog2(AWAIT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]            TMO_LOAD = TMO_W'(AWAIT_TIMEOUT - 1);
  localparam logic [FB_ADDRW-1:0]         CLR_LAST = FB_ADDRW'(DRAW_W * DRAW_H - 1);
  localparam logic [SOURCE_SEL_ADDRW-1:0] IDX_LAST = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);

  dwm_state_e                  state;
  dwm_state_e                  state_nx;
  logic [SOURCE_SEL_ADDRW-1:0] idx;
  logic [FB_ADDRW-1:0]         clr_cnt;
  logic [TMO_W-1:0]            tmo_cnt;

  logic                        sampling;
  logic                        active;
  logic                        pixel;
  logic                        tmo_hit;

  logic                        pix_we_q;
  logic [COLOR_DEPTH-1:0]      pix_color_q;
  logic [FB_ADDRW-1:0]         pix_addr;
  logic                        pix_inb;

  assign sampling = (state == AWAIT) || (state == STREAM);
  assign active   = sampling && is_high(bus.write_active);
  assign pixel    = active && !is_high(bus.write_transparent);
  assign tmo_hit  = (state == AWAIT) && !active && (tmo_cnt == '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = clear_en ? CLEAR : SELECT;
      CLEAR:   if (clr_cnt == CLR_LAST) state_nx = SELECT;
      SELECT:  state_nx = AWAIT;
      AWAIT: begin
        if (active)              state_nx = STREAM;
        else if (tmo_cnt == '0)  state_nx = NEXT;
      end
      STREAM:  if (!active) state_nx = NEXT;
      NEXT:    state_nx = (idx == IDX_LAST) ? DONE : SELECT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idx     <= '0;
      clr_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            idx     <= '0;
            clr_cnt <= '0;
          end
        end
        CLEAR:  clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
        SELECT: tmo_cnt <= TMO_LOAD;
        AWAIT:  if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
        NEXT:   if (idx != IDX_LAST) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Pixel pipeline: data captured in the pixel's cycle, written the next.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_we_q    <= 1'b0;
      pix_color_q <= '0;
    end else begin
      pix_we_q <= pixel;
      if (sampling) pix_color_q <= bus.write_color_data;
    end
  end

  draw_pixel_addr #(
    .DRAW_W (DRAW_W),
    .DRAW_H (DRAW_H)
  ) u_pixel_addr (
    .clk       (clk),
    .resetN    (resetN),
    .sample_en (sampling),
    .x         (bus.write_x_addr),
    .y         (bus.write_y_addr),
    .addr      (pix_addr),
    .in_bounds (pix_inb)
  );

  // Clear writes and pixel writes never overlap: a pixel write lands at the
  // latest in NEXT, and CLEAR is only entered from IDLE.
  always_comb begin
    bus.write_source_sel = '0;
    bus.write_awaited    = 1'b0;
    fb_we                = 1'b0;
    fb_addr              = '0;
    fb_wdata             = '0;
    frame_done           = (state == DONE);
    source_timeout       = tmo_hit;
    frame_overrun        = frame_start && (state != IDLE);

    if (state inside {SELECT, AWAIT, STREAM, NEXT}) bus.write_source_sel = idx;
    if (state inside {SELECT, AWAIT, STREAM})       bus.write_awaited    = 1'b1;

    if (state == CLEAR) begin
      fb_we    = 1'b1;
      fb_addr  = clr_cnt;
      fb_wdata = bg_color;
    end else if (pix_we_q && pix_inb) begin
      fb_we    = 1'b1;
      fb_addr  = pix_addr;
      fb_wdata = pix_color_q;
    end
  end

endmodule

// File: tb/tb_draw_write_manager.sv
// Bench for draw_write_manager: a full-size instance for the compose flow
// and a small 8x4 instance so a complete clear can be walked address by
// address.
module tb_draw_write_manager;
  import draw_write_manager_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  logic                   fs = 1'b0;
  logic                   clr = 1'b0;
  logic [COLOR_DEPTH-1:0] bg = '0;
  logic                   fb_we;
  logic [FB_ADDRW-1:0]    fb_addr;
  logic [COLOR_DEPTH-1:0] fb_wdata;
  logic                   frame_done, source_timeout, frame_overrun;

  logic                   fs_s = 1'b0;
  logic                   clr_s = 1'b0;
  logic [COLOR_DEPTH-1:0] bg_s = '0;
  logic                   fb_we_s;
  logic [FB_ADDRW-1:0]    fb_addr_s;
  logic [COLOR_DEPTH-1:0] fb_wdata_s;
  logic                   frame_done_s, source_timeout_s, frame_overrun_s;

  draw_write_manager_if bus ();
  draw_write_manager_if bus_s ();

  draw_write_manager dut (
    .clk(clk), .resetN(resetN), .frame_start(fs), .clear_en(clr), .bg_color(bg),
    .bus(bus.master), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .frame_done(frame_done), .source_timeout(source_timeout), .frame_overrun(frame_overrun)
  );

  draw_write_manager #(.SOURCE_COUNT(2), .AWAIT_TIMEOUT(4), .DRAW_W(8), .DRAW_H(4)) dut_s (
    .clk(clk), .resetN(resetN), .frame_start(fs_s), .clear_en(clr_s), .bg_color(bg_s),
    .bus(bus_s.master), .fb_we(fb_we_s), .fb_addr(fb_addr_s), .fb_wdata(fb_wdata_s),
    .frame_done(frame_done_s), .source_timeout(source_timeout_s), .frame_overrun(frame_overrun_s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic                         fs, act, tr;
    logic [DRAW_WIDTH_ADDRW-1:0]  x;
    logic [DRAW_HEIGHT_ADDRW-1:0] y;
    logic [COLOR_DEPTH-1:0]       col;
    logic                         aw;
    logic [SOURCE_SEL_ADDRW-1:0]  sel;
    logic                         we;
    logic [FB_ADDRW-1:0]          addr;
    logic [COLOR_DEPTH-1:0]       wd;
    logic                         to, done, ovr;
    int                           n;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int fs_i, int act_i, int tr_i, int x_i, int y_i, int col_i,
                              int aw_i, int sel_i, int we_i, int addr_i, int wd_i,
                              int to_i, int dn_i, int ov_i, int n_i);
    vec_t v;
    v.fs = 1'(fs_i);   v.act = 1'(act_i); v.tr = 1'(tr_i);
    v.x = DRAW_WIDTH_ADDRW'(x_i); v.y = DRAW_HEIGHT_ADDRW'(y_i); v.col = COLOR_DEPTH'(col_i);
    v.aw = 1'(aw_i);   v.sel = SOURCE_SEL_ADDRW'(sel_i); v.we = 1'(we_i);
    v.addr = FB_ADDRW'(addr_i); v.wd = COLOR_DEPTH'(wd_i);
    v.to = 1'(to_i);   v.done = 1'(dn_i); v.ovr = 1'(ov_i);
    v.n = n_i;
    return v;
  endfunction

  task automatic chk(input string nm, input int got, input int exp_v);
    n_tests++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".fb_we"},    int'(fb_we), 0);
    chk({nm, ".fb_addr"},  int'(fb_addr), 0);
    chk({nm, ".fb_wdata"}, int'(fb_wdata), 0);
    chk({nm, ".awaited"},  int'(bus.write_awaited), 0);
    chk({nm, ".sel"},      int'(bus.write_source_sel), 0);
    chk({nm, ".done"},     int'(frame_done), 0);
    chk({nm, ".timeout"},  int'(source_timeout), 0);
    chk({nm, ".overrun"},  int'(frame_overrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nwr, ndone, nto, seen;
    int last_addr, last_wd;

    bus.write_active = 1'b0;   bus.write_transparent = 1'b0;
    bus.write_color_data = '0; bus.write_x_addr = '0; bus.write_y_addr = '0;
    bus_s.write_active = 1'b0; bus_s.write_transparent = 1'b0;
    bus_s.write_color_data = '0; bus_s.write_x_addr = '0; bus_s.write_y_addr = '0;

    // --- reset state
    cyc();
    chk_all_zero("reset");
    chk("reset.s_fb_we", int'(fb_we_s), 0);
    chk("reset.s_awaited", int'(bus_s.write_awaited), 0);
    cyc();
    resetN = 1'b1;

    // --- full-size frame, four sources, no clear
    //          fs act tr   x    y   col | aw sel we addr    wd  to dn ov  n
    tbl.push_back(mk(1, 0, 0,   0,   0, 'h00, 0, 0, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 0, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,   1,   0, 'h11, 1, 0, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 0, 1,      1, 'h11, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 0, 0, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 1, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  10,   2, 'hFF, 1, 1, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 700,   5, 'hAA, 1, 1, 1,   1290, 'hFF, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1,   3,   3, 'h33, 1, 1, 0,      0, 'h00, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 1, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 0, 1, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 2, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 2, 0,      0, 'h00, 0, 0, 0, 15));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 2, 0,      0, 'h00, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 0, 2, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 3, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 639, 479, 'h5A, 1, 3, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,   0, 480, 'h77, 1, 3, 1, 307199, 'h5A, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 1, 3, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 0, 3, 0,      0, 'h00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0,   0,   0, 'h00, 0, 0, 0,      0, 'h00, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0,   0,   0, 'h00, 0, 0, 0,      0, 'h00, 0, 0, 0, 2));

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        cyc();
        fs = tbl[i].fs;
        bus.write_active      = tbl[i].act;
        bus.write_transparent = tbl[i].tr;
        bus.write_x_addr      = tbl[i].x;
        bus.write_y_addr      = tbl[i].y;
        bus.write_color_data  = tbl[i].col;
        #1;
        chk($sformatf("v%0d.awaited", i), int'(bus.write_awaited), int'(tbl[i].aw));
        chk($sformatf("v%0d.sel", i),     int'(bus.write_source_sel), int'(tbl[i].sel));
        chk($sformatf("v%0d.fb_we", i),   int'(fb_we), int'(tbl[i].we));
        if (tbl[i].we) begin
          chk($sformatf("v%0d.fb_addr", i),  int'(fb_addr), int'(tbl[i].addr));
          chk($sformatf("v%0d.fb_wdata", i), int'(fb_wdata), int'(tbl[i].wd));
        end
        chk($sformatf("v%0d.timeout", i), int'(source_timeout), int'(tbl[i].to));
        chk($sformatf("v%0d.done", i),    int'(frame_done), int'(tbl[i].done));
        chk($sformatf("v%0d.overrun", i), int'(frame_overrun), int'(tbl[i].ovr));
      end
    end
    fs = 1'b0;
    bus.write_active = 1'b0;

    // --- small instance: complete clear of 8x4, then two timed-out sources
    cyc();
    fs_s = 1'b1; clr_s = 1'b1; bg_s = 8'hC3;
    #1;
    chk("clr.idle_we", int'(fb_we_s), 0);
    for (int k = 0; k < 32; k++) begin
      cyc();
      fs_s = 1'b0;
      #1;
      chk($sformatf("clr%0d.we", k),    int'(fb_we_s), 1);
      chk($sformatf("clr%0d.addr", k),  int'(fb_addr_s), k);
      chk($sformatf("clr%0d.wdata", k), int'(fb_wdata_s), 'hC3);
      chk($sformatf("clr%0d.aw", k),    int'(bus_s.write_awaited), 0);
    end
    cyc();
    #1;
    chk("clr.sel_aw",  int'(bus_s.write_awaited), 1);
    chk("clr.sel_id",  int'(bus_s.write_source_sel), 0);
    chk("clr.sel_we",  int'(fb_we_s), 0);
    nto = 0; nwr = 0; seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      cyc();
      #1;
      if (source_timeout_s) nto++;
      if (fb_we_s) nwr++;
      if (frame_done_s) seen = 1;
    end
    chk("clr.done_seen", seen, 1);
    chk("clr.timeouts", nto, 2);
    chk("clr.writes_after", nwr, 0);

    // --- reset in the middle of STREAM
    cyc(); fs = 1'b1; #1;
    cyc(); fs = 1'b0; #1;
    chk("mid.sel_aw", int'(bus.write_awaited), 1);
    cyc();
    bus.write_active = 1'b1; bus.write_x_addr = 10'd5; bus.write_y_addr = 9'd0;
    bus.write_color_data = 8'h21;
    #1;
    cyc();
    bus.write_x_addr = 10'd6; bus.write_color_data = 8'h22;
    #1;
    chk("mid.stream_we",   int'(fb_we), 1);
    chk("mid.stream_addr", int'(fb_addr), 5);
    resetN = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    bus.write_active = 1'b0;
    cyc();
    cyc();
    resetN = 1'b1;
    #1;
    chk_all_zero("rst_release");
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      chk($sformatf("post_rst%0d.done", k), int'(frame_done), 0);
      chk($sformatf("post_rst%0d.we", k),   int'(fb_we), 0);
    end

    // --- next frame composes normally
    cyc(); fs = 1'b1; #1;
    chk("nf.idle_aw", int'(bus.write_awaited), 0);
    cyc(); fs = 1'b0; #1;
    chk("nf.sel_aw", int'(bus.write_awaited), 1);
    chk("nf.sel_id", int'(bus.write_source_sel), 0);
    cyc();
    bus.write_active = 1'b1; bus.write_transparent = 1'b0;
    bus.write_x_addr = 10'd7; bus.write_y_addr = 9'd1; bus.write_color_data = 8'h42;
    #1;
    nwr = 0; ndone = 0; nto = 0; seen = 0; last_addr = -1; last_wd = -1;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      cyc();
      bus.write_active = 1'b0;
      #1;
      if (fb_we) begin
        nwr++;
        last_addr = int'(fb_addr);
        last_wd   = int'(fb_wdata);
      end
      if (source_timeout) nto++;
      if (frame_done) begin
        ndone++;
        seen = 1;
      end
    end
    chk("nf.done_seen", seen, 1);
    chk("nf.writes",    nwr, 1);
    chk("nf.addr",      last_addr, 647);
    chk("nf.wdata",     last_wd, 'h42);
    chk("nf.timeouts",  nto, 3);
    cyc();
    #1;
    chk("nf.done_once", int'(frame_done) + ndone, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
